// File: rtl/sha3_pkg.sv
// Shared SHA-3 types and helpers: the 5x5x64 state, rate constants, lane
// lookup by linear index, and byte reversal used on the squeeze output.
package sha3_pkg;

    typedef logic [0:4][0:4][63:0] state_t;

    localparam int RATE_SHA3_224 = 18;
    localparam int RATE_SHA3_256 = 17;
    localparam int RATE_SHA3_384 = 13;
    localparam int RATE_SHA3_512 = 9;
    localparam int RATE_SHAKE128 = 21;
    localparam int RATE_SHAKE256 = 17;

    // Linear lane index i = x + 5*y, the same order used on the absorb side.
    function automatic logic [63:0] lane_at(input state_t s, input logic [4:0] idx);
        logic [2:0] x;
        logic [2:0] y;
        x = 3'(idx % 5);
        y = 3'(idx / 5);
        return s[x][y];
    endfunction

    function automatic logic [63:0] byte_reverse(input logic [63:0] w);
        logic [63:0] r;
        for (int b = 0; b < 8; b++) begin
            r[8*b +: 8] = w[56-8*b +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/keccak_squeeze_if.sv
// Handshake bundle between the squeeze block, the permutation core and the
// digest consumer.
interface keccak_squeeze_if;
    import sha3_pkg::*;

    state_t      State_in;
    logic        State_valid;
    logic        State_ready;
    logic        Perm_req;
    state_t      Perm_state;
    logic [63:0] Dout;
    logic        Dout_valid;
    logic        Dout_ready;
    logic        Dout_last;
    logic        Busy;

    modport slave (
        input  State_in, State_valid, Dout_ready,
        output State_ready, Perm_req, Perm_state, Dout, Dout_valid, Dout_last, Busy
    );

    modport master (
        output State_in, State_valid, Dout_ready,
        input  State_ready, Perm_req, Perm_state, Dout, Dout_valid, Dout_last, Busy
    );
endinterface

// File: rtl/keccak_squeeze.sv
// Squeeze stage: holds the permuted Keccak state and streams byte-reversed
// lanes out, asking for further permutations once a rate block is exhausted.
//
// state     | meaning
// IDLE      | waiting for a final permuted state
// SEND      | presenting output words, one per accept
// PERM_WAIT | rate exhausted, waiting for the re-permuted state
module keccak_squeeze
    import sha3_pkg::*;
#(
    parameter int WIDTH      = 64,
    parameter int RATE_LANES = 17,
    parameter int OUT_LANES  = 4
) (
    input  logic             clk,
    input  logic             rst,
    keccak_squeeze_if.slave  bus
);

    localparam int CW = $clog2(OUT_LANES + 1);
    localparam logic [4:0]    LAST_LANE = 5'(RATE_LANES - 1);
    localparam logic [CW-1:0] LAST_WORD = CW'(OUT_LANES - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SEND      = 2'd1,
        PERM_WAIT = 2'd2
    } sq_state_t;

    sq_state_t        state_q, state_d;
    logic [4:0]       lane_q, lane_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    state_t           held_q, held_d;
    logic [WIDTH-1:0] dout_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            lane_q  <= '0;
            cnt_q   <= '0;
            held_q  <= '0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            cnt_q   <= cnt_d;
            held_q  <= held_d;
            // Follows the next word so it is stable whenever Dout_valid is high.
            dout_q  <= WIDTH'(byte_reverse(lane_at(held_d, lane_d)));
        end
    end

    always_comb begin
        state_d = state_q;
        lane_d  = lane_q;
        cnt_d   = cnt_q;
        held_d  = held_q;
        unique case (state_q)
            IDLE: begin
                if (bus.State_valid) begin
                    held_d  = bus.State_in;
                    lane_d  = '0;
                    cnt_d   = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (bus.Dout_ready) begin
                    if (cnt_q == LAST_WORD) begin
                        state_d = IDLE;
                    end else if (lane_q == LAST_LANE) begin
                        lane_d  = '0;
                        cnt_d   = cnt_q + 1'b1;
                        state_d = PERM_WAIT;
                    end else begin
                        lane_d = lane_q + 5'd1;
                        cnt_d  = cnt_q + 1'b1;
                    end
                end
            end
            PERM_WAIT: begin
                if (bus.State_valid) begin
                    held_d  = bus.State_in;
                    state_d = SEND;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.Dout        = dout_q;
    assign bus.Dout_valid  = (state_q == SEND);
    assign bus.Dout_last   = (state_q == SEND) && (cnt_q == LAST_WORD);
    assign bus.Perm_req    = (state_q == PERM_WAIT);
    assign bus.Perm_state  = held_q;
    assign bus.State_ready = (state_q != SEND);
    assign bus.Busy        = (state_q != IDLE);

endmodule

// File: tb/tb_keccak_squeeze.sv
// Randomized bench for keccak_squeeze: three instances (single word, SHA3-256,
// multi-block SHAKE-style) checked against a queue-of-states reference model.
module tb_keccak_squeeze;
    import sha3_pkg::*;

    localparam int NDUT = 3;
    localparam int RATE [NDUT] = '{17, 2, 17};
    localparam int OUTS [NDUT] = '{4, 5, 1};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst    [NDUT];
    state_t      st_in  [NDUT];
    logic        st_val [NDUT];
    logic        dr     [NDUT];
    logic [63:0] dout   [NDUT];
    logic        dval   [NDUT];
    logic        dlast  [NDUT];
    logic        preq   [NDUT];
    logic        busy   [NDUT];
    logic        sready [NDUT];
    state_t      pstate [NDUT];

    int checks = 0;
    int errors = 0;

    keccak_squeeze_if ifc_a ();
    keccak_squeeze_if ifc_b ();
    keccak_squeeze_if ifc_c ();

    keccak_squeeze #(.WIDTH(64), .RATE_LANES(17), .OUT_LANES(4))
        dut_a (.clk(clk), .rst(rst[0]), .bus(ifc_a.slave));
    keccak_squeeze #(.WIDTH(64), .RATE_LANES(2), .OUT_LANES(5))
        dut_b (.clk(clk), .rst(rst[1]), .bus(ifc_b.slave));
    keccak_squeeze #(.WIDTH(64), .RATE_LANES(17), .OUT_LANES(1))
        dut_c (.clk(clk), .rst(rst[2]), .bus(ifc_c.slave));

    assign ifc_a.State_in = st_in[0];  assign ifc_a.State_valid = st_val[0];  assign ifc_a.Dout_ready = dr[0];
    assign ifc_b.State_in = st_in[1];  assign ifc_b.State_valid = st_val[1];  assign ifc_b.Dout_ready = dr[1];
    assign ifc_c.State_in = st_in[2];  assign ifc_c.State_valid = st_val[2];  assign ifc_c.Dout_ready = dr[2];

    assign dout[0] = ifc_a.Dout;  assign dval[0] = ifc_a.Dout_valid;  assign dlast[0] = ifc_a.Dout_last;
    assign dout[1] = ifc_b.Dout;  assign dval[1] = ifc_b.Dout_valid;  assign dlast[1] = ifc_b.Dout_last;
    assign dout[2] = ifc_c.Dout;  assign dval[2] = ifc_c.Dout_valid;  assign dlast[2] = ifc_c.Dout_last;
    assign preq[0] = ifc_a.Perm_req;  assign busy[0] = ifc_a.Busy;  assign sready[0] = ifc_a.State_ready;
    assign preq[1] = ifc_b.Perm_req;  assign busy[1] = ifc_b.Busy;  assign sready[1] = ifc_b.State_ready;
    assign preq[2] = ifc_c.Perm_req;  assign busy[2] = ifc_c.Busy;  assign sready[2] = ifc_c.State_ready;
    assign pstate[0] = ifc_a.Perm_state;
    assign pstate[1] = ifc_b.Perm_state;
    assign pstate[2] = ifc_c.Perm_state;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    // mode 0: random lanes; 1: lane i holds i; 2: lane(0,0)=0706050403020100
    function automatic state_t make_state(input int mode);
        state_t s;
        for (int i = 0; i < 25; i++) begin
            s[i % 5][i / 5] = (mode == 1) ? 64'(i) : rnd64();
        end
        if (mode == 2) s[0][0] = 64'h0706050403020100;
        return s;
    endfunction

    // Word j of the digest is lane (j mod rate) of the (j div rate)-th state,
    // with its byte order reversed.
    function automatic logic [63:0] model_word(input state_t blocks[$], input int j, input int r);
        logic [63:0] w;
        int lane;
        lane = j % r;
        w = blocks[j / r][lane % 5][lane / 5];
        return {<<8{w}};
    endfunction

    task automatic run_digest(input int k, input int mode, input int stall_pct, input int abort_at);
        state_t      blocks[$];
        state_t      s;
        int          beat, cyc, r, n;
        bit          stalled, rdy;
        logic [63:0] prev_dout;
        logic        prev_last;
        r = RATE[k];
        n = OUTS[k];
        s = make_state(mode);
        blocks.push_back(s);
        @(negedge clk);
        chk("ready_idle", 64'(sready[k]), 64'd1);
        st_in[k]  = s;
        st_val[k] = 1'b1;
        @(negedge clk);
        st_val[k] = 1'b0;
        beat = 0;
        cyc = 0;
        stalled = 1'b0;
        prev_dout = '0;
        prev_last = 1'b0;
        while (beat < n && cyc < 500 && !(abort_at >= 0 && beat == abort_at)) begin
            if (dval[k]) begin
                if (stalled) begin
                    chk("stall_dout", dout[k], prev_dout);
                    chk("stall_last", 64'(dlast[k]), 64'(prev_last));
                end
                chk("preq_in_send", 64'(preq[k]), 64'd0);
                chk("ready_in_send", 64'(sready[k]), 64'd0);
                rdy = ($urandom_range(0, 99) >= stall_pct);
                dr[k] = rdy;
                if ($urandom_range(0, 3) == 0) begin
                    st_in[k]  = make_state(0);
                    st_val[k] = 1'b1;
                end
                if (rdy) begin
                    chk("dout", dout[k], model_word(blocks, beat, r));
                    chk("last", 64'(dlast[k]), 64'(beat == n - 1));
                    beat++;
                end
                stalled   = !rdy;
                prev_dout = dout[k];
                prev_last = dlast[k];
            end else if (preq[k]) begin
                chk("perm_point", 64'((beat > 0) && (beat % r == 0)), 64'd1);
                chk("ready_in_perm", 64'(sready[k]), 64'd1);
                for (int i = 0; i < 25; i++) begin
                    chk("perm_state", pstate[k][i % 5][i / 5], blocks[blocks.size() - 1][i % 5][i / 5]);
                end
                s = make_state(0);
                blocks.push_back(s);
                st_in[k]  = s;
                st_val[k] = 1'b1;
                dr[k]     = 1'b1;
                stalled   = 1'b0;
            end else begin
                chk("unexpected_idle", 64'(busy[k]), 64'd1);
                cyc = 500;
            end
            @(negedge clk);
            st_val[k] = 1'b0;
            cyc++;
        end
        dr[k] = 1'b0;
        chk("no_timeout", 64'(cyc < 500), 64'd1);
        if (abort_at >= 0 && beat == abort_at) begin
            rst[k] = 1'b1;
            #1;
            chk("rst_dval", 64'(dval[k]), 64'd0);
            chk("rst_busy", 64'(busy[k]), 64'd0);
            chk("rst_dout", dout[k], 64'd0);
            chk("rst_preq", 64'(preq[k]), 64'd0);
            chk("rst_ready", 64'(sready[k]), 64'd1);
            @(negedge clk);
            rst[k] = 1'b0;
        end else begin
            chk("idle_dval", 64'(dval[k]), 64'd0);
            chk("idle_busy", 64'(busy[k]), 64'd0);
            chk("idle_ready", 64'(sready[k]), 64'd1);
        end
    endtask

    initial begin
        for (int k = 0; k < NDUT; k++) begin
            rst[k]    = 1'b1;
            st_in[k]  = '0;
            st_val[k] = 1'b0;
            dr[k]     = 1'b0;
        end
        #12;
        for (int k = 0; k < NDUT; k++) begin
            chk("reset_dout", dout[k], 64'd0);
            chk("reset_dval", 64'(dval[k]), 64'd0);
            chk("reset_last", 64'(dlast[k]), 64'd0);
            chk("reset_preq", 64'(preq[k]), 64'd0);
            chk("reset_busy", 64'(busy[k]), 64'd0);
            chk("reset_ready", 64'(sready[k]), 64'd1);
            chk("reset_held", pstate[k][4][4] | pstate[k][0][0], 64'd0);
        end
        @(negedge clk);
        for (int k = 0; k < NDUT; k++) rst[k] = 1'b0;

        // Single-word digest, including the fixed 0706..00 pattern.
        run_digest(2, 2, 0, -1);
        for (int t = 0; t < 3; t++) run_digest(2, 0, 40, -1);

        // SHA3-256: incrementing lanes at full throughput, then with stalls.
        run_digest(0, 1, 0, -1);
        for (int t = 0; t < 4; t++) run_digest(0, 0, 40, -1);
        run_digest(0, 0, 30, 2);
        run_digest(0, 1, 0, -1);

        // Extendable output across three rate blocks.
        run_digest(1, 0, 0, -1);
        for (int t = 0; t < 4; t++) run_digest(1, 0, 35, -1);
        run_digest(1, 0, 20, 2);
        run_digest(1, 0, 0, -1);
        run_digest(1, 0, 0, 4);
        run_digest(1, 1, 50, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/keccak_squeeze.md
Name: keccak_squeeze

Overview:
Squeeze-side companion to keccak_xor. It captures the final 5x5 Keccak state once the last absorbed block has been permuted. It then streams the digest out as byte-reversed 64-bit words over a valid/ready interface. When the requested output exceeds the rate (SHAKE-style extendable output), it requests extra permutations from the permutation core and resumes on the returned state.

Parameters:
WIDTH, 64, lane width in bits; fixed at 64 for this block.
RATE_LANES, 17, lanes per squeeze block; 17 = SHA3-256 rate of 1088 bits; legal range 1..25.
OUT_LANES, 4, total 64-bit output words per digest (4 = 256 bits); legal range 1..1023.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst  in  1  asynchronous, active-high reset.
State_in  in  [0:4][0:4][WIDTH-1:0]  permuted Keccak state; lane (x,y) is State_in[x][y].
State_valid  in  1  State_in is valid this cycle.
State_ready  out  1  block can capture State_in.
Perm_req  out  1  level request for one further permutation of the held state.
Perm_state  out  [0:4][0:4][WIDTH-1:0]  held state, presented to the permutation core while Perm_req=1.
Dout  out  WIDTH  output word, byte-reversed lane (lane byte 0 in Dout[63:56]).
Dout_valid  out  1  Dout is valid.
Dout_ready  in  1  consumer accepts Dout this cycle.
Dout_last  out  1  current word is the final digest word.
Busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, rst=1): state IDLE, lane_idx=0, out_cnt=0, held state cleared to 0.
- Output reset values: Dout=0, Dout_valid=0, Dout_last=0, Perm_req=0, Busy=0, State_ready=1.
- Lane order: linear index i = x + 5*y, so lanes go (0,0),(1,0),...,(4,0),(0,1),... as in absorb.
- Dout = byte_reverse(held[i mod 5][i / 5]), registered.
- States:
  - IDLE: State_ready=1. On State_valid, capture State_in, lane_idx=0, out_cnt=0, go to SEND.
  - SEND: Dout_valid=1 starting the cycle after capture (1-cycle capture-to-first-word latency). Accept occurs when Dout_valid & Dout_ready.
  - On accept with out_cnt==OUT_LANES-1: go to IDLE, Dout_valid=0 next cycle.
  - On accept with lane_idx==RATE_LANES-1 but more output needed: go to PERM_WAIT, lane_idx=0.
  - Any other accept: lane_idx++, out_cnt++, next word presented in the following cycle (full throughput, 1 word/cycle).
  - PERM_WAIT: Perm_req=1, State_ready=1, Dout_valid=0. On State_valid, capture State_in and go to SEND; Perm_req drops the same cycle.
- Stall: while Dout_valid=1 and Dout_ready=0, Dout, Dout_last and the counters hold stable.
- Dout_last=1 exactly when Dout_valid=1 and out_cnt==OUT_LANES-1.
- State_valid in SEND is ignored (State_ready=0). State_valid and an accept in the same cycle cannot conflict, since they occur in different states.
- OUT_LANES <= RATE_LANES: PERM_WAIT is never entered.
- rst asserted mid-stream: everything returns to reset values immediately; any partial digest is discarded.
- Counter widths: lane_idx is 5 bits; out_cnt is $clog2(OUT_LANES+1) bits; no wrap-around is reachable.

Decomposition:
- sha3_pkg holds:
  - state_t typedef ([0:4][0:4][63:0]);
  - the RATE constants per variant (224:18, 256:17, 384:13, 512:9, SHAKE128:21, SHAKE256:17);
  - function lane_at(state_t, idx);
  - function byte_reverse(64-bit), shared with benches.
- No sub-module; a single module with one FSM and two counters.

Test Plan:
- Single word: held lane(0,0)=64'h0706050403020100, OUT_LANES=1 -> one beat, Dout=64'h0001020304050607, Dout_last=1, then IDLE and State_ready=1.
- SHA3-256 stream: lane i = 64'h00000000000000ii, OUT_LANES=4, Dout_ready=1 -> 4 consecutive beats, Dout = 64'hii00000000000000 for i=0..3, Dout_last only on the 4th beat, Perm_req stays 0.
- Backpressure: drop Dout_ready for 3 cycles mid-stream -> Dout and Dout_last held, no word lost or repeated.
- Multi-block squeeze: RATE_LANES=2, OUT_LANES=5 -> Perm_req rises after beats 2 and 4. Supply new states with lane(0,0)=A, B -> beats 3 and 5 equal byte_reverse(A) and byte_reverse(B).
- Reset mid-stream: assert rst after beat 2 -> Dout_valid=0 and Busy=0 immediately. A new State_valid restarts from lane 0.
- State_valid pulsed during SEND -> ignored; the output sequence is unchanged.
